rom_read_sequencer: RTL and testbench

- Upstream driver for the 16x16 synchronous ROM.
- Accepts a burst command (start address, length) and issues r_en/addr to the ROM one word per cycle.
- Captures the returned words in a 2-entry output buffer and streams them downstream on a valid/ready interface.
- Fills the gap between a DMA/command source and the ROM, so that downstream backpressure never drops a ROM word.

---
 rtl/rom_seq_pkg.sv | 17 +
 rtl/rom_read_sequencer_if.sv | 35 +++
 rtl/rom_seq_fifo2.sv | 52 +++++
 rtl/rom_read_sequencer.sv | 103 ++++++++++
 tb/tb_rom_read_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_seq_pkg.sv
// Shared constants and FSM state type for the ROM read sequencer.
// ROM geometry matches the 16x16 synchronous ROM this block drives.
package rom_seq_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 16;
  localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;
  localparam int ROM_RD_LAT = 1;
  localparam int SEQ_LEN_W  = ROM_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/rom_read_sequencer_if.sv
// Bundles the command, ROM and output-stream signals of the sequencer.
// master = sequencer side, slave = surrounding system (command source, ROM, sink).
interface rom_read_sequencer_if
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int LEN_W  = SEQ_LEN_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              rom_r_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, rom_data, m_ready,
    output cmd_ready, rom_r_en, rom_addr, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, rom_data, m_ready,
    input  cmd_ready, rom_r_en, rom_addr, m_valid, m_data, m_last, busy, done
  );

endinterface

// File: rtl/rom_seq_fifo2.sv
// Two-entry register FIFO; slot0 is always the head so the output comes
// straight from a register and stays stable while nothing is popped.
module rom_seq_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   count;
  logic         pop_ok;
  logic         push_ok;
  logic [1:0]   after_pop;

  assign pop_ok    = pop && (count != 2'd0);
  assign push_ok   = push && ((count != 2'd2) || pop_ok);
  assign after_pop = count - {1'b0, pop_ok};

  // The pushed word lands in the first free slot after the pop has shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      if (pop_ok) begin
        slot0 <= slot1;
      end
      if (push_ok) begin
        if (after_pop == 2'd0) begin
          slot0 <= din;
        end else begin
          slot1 <= din;
        end
      end
      count <= after_pop + {1'b0, push_ok};
    end
  end

  assign dout  = slot0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/rom_read_sequencer.sv
// Reads bursts of words from a 1-cycle-latency synchronous ROM and streams
// them out through a 2-entry buffer, issuing reads only when space is guaranteed.
module rom_read_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int LEN_W  = SEQ_LEN_W
) (
  input logic                  clk,
  input logic                  rst_n,
  rom_read_sequencer_if.master bus
);

  seq_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic              inflight_last;
  logic              done_q;

  logic [DATA_W:0]   head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occ;
  logic [2:0]        pending;
  logic              pop;
  logic              issue;

  rom_seq_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   ({inflight_last, bus.rom_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A read may go out only if its word is sure to find a free slot when it returns.
  assign pop     = !fifo_empty && bus.m_ready;
  assign occ     = {fifo_full, !fifo_empty && !fifo_full};
  assign pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue   = (state == ISSUE) && (pending < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_W'(1));
      done_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q    <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            if (bus.cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q    <= addr_q + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Popping the tagged word means the buffer empties with nothing in flight.
          if (pop && head[DATA_W]) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.rom_r_en  = issue;
  assign bus.rom_addr  = addr_q;
  assign bus.m_valid   = !fifo_empty;
  assign bus.m_data    = head[DATA_W-1:0];
  assign bus.m_last    = !fifo_empty && head[DATA_W];

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Bench for rom_read_sequencer: ROM model, directed scenarios with literal
// expectations, and randomized bursts checked against a burst-level model.
module tb_rom_read_sequencer;
  import rom_seq_pkg::*;

  logic clk;
  logic rst_n;
  rom_read_sequencer_if bus ();

  rom_read_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [15:0] mem [ROM_DEPTH];
  logic [16:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        got_last_q[$];
  int          issued;
  int          cur_len;
  logic [3:0]  cur_addr;
  bit          done_due;
  bit          prev_stall;
  logic [15:0] prev_data;
  bit          rand_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.rom_r_en) bus.rom_data <= mem[bus.rom_addr];
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Burst-level model: each accepted command owes len words read from
  // consecutive (wrapping) addresses, then one done pulse the next cycle.
  always @(negedge clk) begin
    logic [16:0] e;
    logic [3:0]  idx;
    if (!rst_n) begin
      exp_q.delete();
      issued     = 0;
      cur_len    = 0;
      cur_addr   = '0;
      done_due   = 0;
      prev_stall = 0;
    end else begin
      checkOutput("done", bus.done, done_due);
      done_due = 0;
      checkOutput("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);
      if (bus.rom_r_en) begin
        idx = cur_addr + 4'(issued);
        checkOutput("read_allowed", issued < cur_len, 1);
        checkOutput("rom_addr", bus.rom_addr, idx);
        issued++;
      end
      if (prev_stall) begin
        checkOutput("hold_valid", bus.m_valid, 1);
        checkOutput("hold_data", bus.m_data, prev_data);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back(bus.m_data);
        got_last_q.push_back(bus.m_last);
        checkOutput("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("m_data", bus.m_data, e[15:0]);
          checkOutput("m_last", bus.m_last, e[16]);
          if (e[16]) done_due = 1;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        cur_addr = bus.cmd_addr;
        cur_len  = int'(bus.cmd_len);
        issued   = 0;
        for (int i = 0; i < cur_len; i++) begin
          idx = cur_addr + 4'(i);
          exp_q.push_back({(i == cur_len - 1), mem[idx]});
        end
        if (cur_len == 0) done_due = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command and returns in the first cycle after acceptance.
  task automatic applyStimulus(input logic [3:0] addr, input logic [4:0] len);
    int n = 0;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("cmd_ready_wait", bus.cmd_ready, 1);
    got_q.delete();
    got_last_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (bus.done !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput("done_seen", bus.done, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic        r_tab  [6];
    logic        v_tab  [6];
    logic [15:0] d_tab  [6];
    logic        l_tab  [6];
    logic        dn_tab [6];
    int          n;

    r_tab  = '{1, 1, 1, 0, 0, 0};
    v_tab  = '{0, 0, 1, 1, 1, 0};
    d_tab  = '{16'h0, 16'h0, 16'h0103, 16'h5200, 16'he0b9, 16'h0};
    l_tab  = '{0, 0, 0, 0, 1, 0};
    dn_tab = '{0, 0, 0, 0, 0, 1};

    for (int i = 0; i < ROM_DEPTH; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'h0103;
    mem[1]  = 16'h5200;
    mem[2]  = 16'he0b9;
    mem[14] = 16'h4444;
    mem[15] = 16'h5555;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b0;
    tick();
    tick();
    checkOutput("rst_rom_r_en", bus.rom_r_en, 0);
    checkOutput("rst_m_valid", bus.m_valid, 0);
    checkOutput("rst_m_data", bus.m_data, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);

    $display("[TB] basic burst");
    bus.m_ready = 1'b1;
    applyStimulus(4'd0, 5'd3);
    for (int k = 0; k < 6; k++) begin
      checkOutput("t1_rom_r_en", bus.rom_r_en, r_tab[k]);
      checkOutput("t1_m_valid", bus.m_valid, v_tab[k]);
      if (v_tab[k]) checkOutput("t1_m_data", bus.m_data, d_tab[k]);
      checkOutput("t1_m_last", bus.m_last, l_tab[k]);
      checkOutput("t1_done", bus.done, dn_tab[k]);
      if (k < 5) tick();
    end
    tick();

    $display("[TB] wrap-around");
    applyStimulus(4'd14, 5'd3);
    checkOutput("t2_addr0", bus.rom_addr, 14);
    tick();
    checkOutput("t2_addr1", bus.rom_addr, 15);
    tick();
    checkOutput("t2_addr2", bus.rom_addr, 0);
    checkOutput("t2_r_en2", bus.rom_r_en, 1);
    wait_done(20);
    checkOutput("t2_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      checkOutput("t2_w0", got_q[0], 16'h4444);
      checkOutput("t2_w1", got_q[1], 16'h5555);
      checkOutput("t2_w2", got_q[2], 16'h0103);
      checkOutput("t2_last1", got_last_q[1], 0);
      checkOutput("t2_last2", got_last_q[2], 1);
    end
    tick();

    $display("[TB] backpressure");
    bus.m_ready = 1'b0;
    applyStimulus(4'd0, 5'd4);
    n = 0;
    while (!bus.m_valid && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("t3_stall_r_en", bus.rom_r_en, 0);
      checkOutput("t3_stall_data", bus.m_data, 16'h0103);
      if (k < 4) tick();
    end
    checkOutput("t3_reads_before_stall", issued, 2);
    tick();
    bus.m_ready = 1'b1;
    wait_done(30);
    checkOutput("t3_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      checkOutput("t3_w0", got_q[0], 16'h0103);
      checkOutput("t3_w1", got_q[1], 16'h5200);
      checkOutput("t3_w2", got_q[2], 16'he0b9);
      checkOutput("t3_last3", got_last_q[3], 1);
    end
    tick();

    $display("[TB] zero length and busy command");
    applyStimulus(4'd5, 5'd0);
    checkOutput("t4_done", bus.done, 1);
    checkOutput("t4_r_en", bus.rom_r_en, 0);
    checkOutput("t4_busy", bus.busy, 0);
    tick();
    checkOutput("t4_done_once", bus.done, 0);
    applyStimulus(4'($urandom_range(0, 15)), 5'd16);
    for (int k = 0; k < 5; k++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 4'd3;
      bus.cmd_len   = 5'd2;
      checkOutput("t4_cmd_ready_busy", bus.cmd_ready, 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    wait_done(60);
    checkOutput("t4_count", got_q.size(), 16);
    tick();

    $display("[TB] reset mid-burst");
    applyStimulus(4'd0, 5'd8);
    n = 0;
    while (got_q.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("t5_r_en", bus.rom_r_en, 0);
    checkOutput("t5_m_valid", bus.m_valid, 0);
    checkOutput("t5_m_data", bus.m_data, 0);
    checkOutput("t5_m_last", bus.m_last, 0);
    checkOutput("t5_busy", bus.busy, 0);
    checkOutput("t5_done", bus.done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t5_cmd_ready", bus.cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t5_no_done", bus.done, 0);
      tick();
    end
    applyStimulus(4'd1, 5'd1);
    wait_done(10);
    checkOutput("t5_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      checkOutput("t5_w0", got_q[0], 16'h5200);
      checkOutput("t5_last0", got_last_q[0], 1);
    end
    tick();

    $display("[TB] random bursts");
    rand_ready = 1;
    for (int b = 0; b < 12; b++) begin
      applyStimulus(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)));
      wait_done(200);
      tick();
    end
    rand_ready = 0;
    tick();
    checkOutput("final_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
